// File: rtl/i2c_config_sequencer_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
package i2c_config_sequencer_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_ACK,
    ST_STOP,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } state_e;

  // Quarter-bit phases: SDA set at Q0, SCL rises at Q1, SDA sampled at Q2,
  // SCL falls at Q3.
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // One write frame: device address, data high byte, data low byte.
  localparam int FRAME_W = 24;

  // True while a bus transfer is in progress (divider running).
  function automatic logic bus_active(state_e s);
    return !(s inside {ST_IDLE, ST_DONE, ST_ERR});
  endfunction

endpackage

// File: rtl/i2c_config_sequencer_if.sv
// I2C bus lines between the sequencer (master) and the bus/slave side.
interface i2c_config_sequencer_if;
  logic oSCL;     // I2C clock, push-pull, idles high
  logic oSDA_OE;  // 1 = pull SDA low, 0 = release to pull-up
  logic iSDA;     // sampled SDA line level

  modport master (output oSCL, output oSDA_OE, input iSDA);
  modport slave  (input oSCL, input oSDA_OE, output iSDA);
endinterface

// File: rtl/i2c_config_sequencer_tick_gen.sv
// Quarter-bit tick divider with enable and a 2-bit quarter counter.
module i2c_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       en_i,       // divider runs only while enabled; cleared otherwise
  input  logic       qclr_i,     // on a tick, restart the quarter count at Q0
  output logic       tick_o,
  output logic [1:0] quarter_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  qtr_q, qtr_d;

  // Next divider/quarter values; tick fires on the last count of each period.
  always_comb begin
    cnt_d  = cnt_q;
    qtr_d  = qtr_q;
    tick_o = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
      qtr_d = '0;
    end else if (cnt_q == 16'(CLK_DIV - 1)) begin
      tick_o = 1'b1;
      cnt_d  = '0;
      qtr_d  = qtr_clr(qclr_i, qtr_q);
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  function automatic logic [1:0] qtr_clr(input logic clr, input logic [1:0] q);
    return clr ? 2'd0 : q + 2'd1;
  endfunction

  // Divider and quarter registers.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cnt_q <= '0;
      qtr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

  assign quarter_o = qtr_q;

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks a register table and writes each 16-bit entry to one I2C device,
// retrying NACKed entries, then reports done or error (both sticky).
// Handshake: iSTART is a level permit sampled only in IDLE; once a run
// starts it completes regardless of iSTART, and oDONE/oERR hold until reset.
module i2c_config_sequencer
  import i2c_config_sequencer_pkg::*;
#(
  parameter int          CLK_DIV   = 250,
  parameter int          LUT_SIZE  = 10,
  parameter logic [7:0]  DEV_ADDR  = 8'h34,
  parameter int          MAX_RETRY = 3,
  parameter int          GAP_TICKS = 8
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iSTART,
  output logic [7:0]             oLUT_INDEX,
  input  logic [15:0]            iLUT_DATA,
  i2c_config_sequencer_if.master bus,
  output logic                   oBUSY,
  output logic                   oDONE,
  output logic                   oERR,
  output logic [7:0]             oERR_INDEX,
  output state_e                 oSTATE
);

  state_e               state_q, state_d;
  logic                 scl_q, scl_d;
  logic                 sda_oe_q, sda_oe_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [2:0]           bit_q, bit_d;
  logic [1:0]           byte_q, byte_d;
  logic [15:0]          gap_q, gap_d;
  logic [7:0]           retry_q, retry_d;
  logic                 nack_q, nack_d;
  logic                 ack_bit_q, ack_bit_d;
  logic [7:0]           idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [7:0]           err_idx_q, err_idx_d;
  logic                 sda_s1_q, sda_s2_q;
  logic                 tick;
  logic [1:0]           quarter;
  logic                 qclr;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .en_i      (bus_active(state_q)),
    .qclr_i    (qclr),
    .tick_o    (tick),
    .quarter_o (quarter)
  );

  // Two-flop synchroniser on the incoming SDA line.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      sda_s1_q <= bus.iSDA;
      sda_s2_q <= sda_s1_q;
    end
  end

  // Next-state and bus-line logic; everything except IDLE exit moves on ticks.
  always_comb begin
    state_d   = state_q;
    scl_d     = scl_q;
    sda_oe_d  = sda_oe_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    gap_d     = gap_q;
    retry_d   = retry_q;
    nack_d    = nack_q;
    ack_bit_d = ack_bit_q;
    idx_d     = idx_q;
    done_d    = done_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iSTART && !done_q && !err_q) state_d = ST_START;
      end
      ST_START: begin
        // Lines enter idle-high; pull SDA, then SCL. The entry is latched
        // here so the index update from the previous GAP has settled.
        if (tick) begin
          if (quarter == Q0) begin
            sda_oe_d = 1'b1;
            shift_d  = {DEV_ADDR, iLUT_DATA};
          end else begin
            scl_d   = 1'b0;
            state_d = ST_SEND;
            bit_d   = '0;
            byte_d  = '0;
            nack_d  = 1'b0;
          end
        end
      end
      ST_SEND: begin
        if (tick) begin
          unique case (quarter)
            Q0: sda_oe_d = ~shift_q[FRAME_W-1];
            Q1: scl_d = 1'b1;
            Q2: ;
            Q3: begin
              scl_d   = 1'b0;
              shift_d = {shift_q[FRAME_W-2:0], 1'b0};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = ST_ACK;
            end
          endcase
        end
      end
      ST_ACK: begin
        if (tick) begin
          unique case (quarter)
            Q0: sda_oe_d = 1'b0;
            Q1: scl_d = 1'b1;
            Q2: ack_bit_d = sda_s2_q;
            Q3: begin
              // SDA is pulled low together with the SCL fall so STOP can
              // begin with SCL rising on the next tick.
              scl_d = 1'b0;
              if (ack_bit_q) begin
                nack_d   = 1'b1;
                sda_oe_d = 1'b1;
                state_d  = ST_STOP;
              end else if (byte_q == 2'd2) begin
                sda_oe_d = 1'b1;
                state_d  = ST_STOP;
              end else begin
                byte_d  = byte_q + 2'd1;
                state_d = ST_SEND;
              end
            end
          endcase
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (quarter == Q0) begin
            scl_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            gap_d    = '0;
            state_d  = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_q == 16'(GAP_TICKS - 1)) begin
            gap_d = '0;
            if (!nack_q) begin
              idx_d   = idx_q + 8'd1;
              retry_d = '0;
              if (idx_q + 8'd1 == 8'(LUT_SIZE)) begin
                done_d  = 1'b1;
                state_d = ST_DONE;
              end else begin
                state_d = ST_START;
              end
            end else if (retry_q < 8'(MAX_RETRY)) begin
              retry_d = retry_q + 8'd1;
              state_d = ST_START;
            end else begin
              err_d     = 1'b1;
              err_idx_d = idx_q;
              state_d   = ST_ERR;
            end
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
      end
      ST_DONE: ;
      ST_ERR:  ;
      default: state_d = ST_IDLE;
    endcase
  end

  // Restart the quarter count whenever a tick moves the FSM to a new state.
  assign qclr = tick && (state_d != state_q);

  // FSM and datapath registers.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q   <= ST_IDLE;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      shift_q   <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      gap_q     <= '0;
      retry_q   <= '0;
      nack_q    <= 1'b0;
      ack_bit_q <= 1'b0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      gap_q     <= gap_d;
      retry_q   <= retry_d;
      nack_q    <= nack_d;
      ack_bit_q <= ack_bit_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign bus.oSCL    = scl_q;
  assign bus.oSDA_OE = sda_oe_q;
  assign oLUT_INDEX  = idx_q;
  assign oBUSY       = bus_active(state_q);
  assign oDONE       = done_q;
  assign oERR        = err_q;
  assign oERR_INDEX  = err_idx_q;
  assign oSTATE      = state_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: I2C slave model with byte scoreboard.
module tb_i2c_config_sequencer;
  import i2c_config_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start;
  logic [7:0]  lut_index;
  logic [15:0] lut_data;
  logic        busy, done, err;
  logic [7:0]  err_index;
  state_e      dbg_state;

  i2c_config_sequencer_if bus();

  i2c_config_sequencer #(
    .CLK_DIV(4), .LUT_SIZE(2), .DEV_ADDR(8'h34), .MAX_RETRY(3), .GAP_TICKS(8)
  ) dut (
    .iCLK       (clk),
    .iRST       (rst_n),
    .iSTART     (start),
    .oLUT_INDEX (lut_index),
    .iLUT_DATA  (lut_data),
    .bus        (bus),
    .oBUSY      (busy),
    .oDONE      (done),
    .oERR       (err),
    .oERR_INDEX (err_index),
    .oSTATE     (dbg_state)
  );

  // Register table.
  assign lut_data = (lut_index == 8'd0) ? 16'h1E00 : 16'h0C00;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  // mode 0: always ACK; 1: NACK low byte of entry 0x0C.. twice; 2: NACK address always
  int   mode = 0;
  logic slave_low;
  logic sda_line;
  assign bus.iSDA = ~(bus.oSDA_OE | slave_low);
  assign sda_line = bus.iSDA;

  logic       prev_scl, prev_sda, in_frame, ack_slot;
  logic [7:0] sh, cur_hi;
  int         bit_n, byte_n, frames, nack_used;

  function automatic logic want_nack(input int m, input int bn, input logic [7:0] hi, input int used);
    if (m == 2) return bn == 0;
    if (m == 1) return (bn == 2) && (hi == 8'h0C) && (used < 2);
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    prev_scl <= bus.oSCL;
    prev_sda <= sda_line;
    if (!rst_n) begin
      in_frame  <= 1'b0;
      ack_slot  <= 1'b0;
      slave_low <= 1'b0;
      bit_n     <= 0;
      byte_n    <= 0;
      frames    <= 0;
      nack_used <= 0;
      cur_hi    <= '0;
    end else if (prev_scl && bus.oSCL && prev_sda && !sda_line) begin
      in_frame  <= 1'b1;
      ack_slot  <= 1'b0;
      bit_n     <= 0;
      byte_n    <= 0;
      slave_low <= 1'b0;
    end else if (prev_scl && bus.oSCL && !prev_sda && sda_line) begin
      if (in_frame) frames <= frames + 1;
      in_frame  <= 1'b0;
      slave_low <= 1'b0;
    end else if (in_frame && !prev_scl && bus.oSCL && !ack_slot) begin
      sh    <= {sh[6:0], sda_line};
      bit_n <= bit_n + 1;
    end else if (in_frame && prev_scl && !bus.oSCL) begin
      if (ack_slot) begin
        ack_slot  <= 1'b0;
        slave_low <= 1'b0;
        bit_n     <= 0;
        byte_n    <= byte_n + 1;
      end else if (bit_n == 8) begin
        ack_slot <= 1'b1;
        if (byte_n == 1) cur_hi <= sh;
        check("bus_byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("bus_byte", 32'(sh), 32'(exp_q.pop_front()));
        if (want_nack(mode, byte_n, (byte_n == 1) ? sh : cur_hi, nack_used)) begin
          slave_low <= 1'b0;
          if (mode == 1) nack_used <= nack_used + 1;
        end else begin
          slave_low <= 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_entry(input logic [7:0] hi, input logic [7:0] lo);
    exp_q.push_back(8'h34);
    exp_q.push_back(hi);
    exp_q.push_back(lo);
  endtask

  task automatic wait_end(input int budget, output int cyc);
    cyc = 0;
    while (!(done || err) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("end_within_budget", 32'(done || err), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int cyc;
  int bad;

  initial begin
    start = 1'b0;
    #12;
    // reset values while iRST held low
    check("rst_scl", 32'(bus.oSCL), 32'd1);
    check("rst_sda_oe", 32'(bus.oSDA_OE), 32'd0);
    check("rst_index", 32'(lut_index), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_index", 32'(err_index), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    do_reset();

    // iSTART low: bus stays idle
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.oSCL !== 1'b1 || bus.oSDA_OE !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_hold_violations", 32'(bad), 32'd0);

    // normal run, all ACK
    do_reset();
    mode = 0;
    repeat (10) @(negedge clk);
    push_entry(8'h1E, 8'h00);
    push_entry(8'h0C, 8'h00);
    start = 1'b1;
    wait_end(4000, cyc);
    check("s1_latency_min", 32'(cyc >= 2 * 112 * 4), 32'd1);
    check("s1_done", 32'(done), 32'd1);
    check("s1_err", 32'(err), 32'd0);
    check("s1_index", 32'(lut_index), 32'd2);
    check("s1_busy", 32'(busy), 32'd0);
    check("s1_frames", 32'(frames), 32'd2);
    check("s1_exp_empty", 32'(exp_q.size()), 32'd0);

    // entry 1 NACKed twice, then ACKed
    do_reset();
    mode = 1;
    push_entry(8'h1E, 8'h00);
    for (int i = 0; i < 3; i++) push_entry(8'h0C, 8'h00);
    start = 1'b1;
    wait_end(6000, cyc);
    check("s2_done", 32'(done), 32'd1);
    check("s2_err", 32'(err), 32'd0);
    check("s2_frames", 32'(frames), 32'd4);
    check("s2_nacks", 32'(nack_used), 32'd2);
    check("s2_exp_empty", 32'(exp_q.size()), 32'd0);

    // entry 0 always NACKed at the address
    do_reset();
    mode = 2;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h34);
    start = 1'b1;
    wait_end(6000, cyc);
    check("s3_err", 32'(err), 32'd1);
    check("s3_err_index", 32'(err_index), 32'd0);
    check("s3_done", 32'(done), 32'd0);
    check("s3_busy", 32'(busy), 32'd0);
    check("s3_state", 32'(dbg_state), 32'(ST_ERR));
    repeat (500) @(negedge clk);
    check("s3_frames_after", 32'(frames), 32'd4);
    check("s3_scl_idle", 32'(bus.oSCL), 32'd1);
    check("s3_sda_idle", 32'(bus.oSDA_OE), 32'd0);
    check("s3_exp_empty", 32'(exp_q.size()), 32'd0);

    // asynchronous reset during the 2nd byte of entry 1
    do_reset();
    mode = 0;
    push_entry(8'h1E, 8'h00);
    exp_q.push_back(8'h34);
    start = 1'b1;
    cyc = 0;
    while (!(frames == 1 && byte_n == 1 && bit_n == 3) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("s4_reached_byte2", 32'(frames == 1 && byte_n == 1 && bit_n == 3), 32'd1);
    check("s4_busy_before", 32'(busy), 32'd1);
    check("s4_index_before", 32'(lut_index), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("s4_async_scl", 32'(bus.oSCL), 32'd1);
    check("s4_async_sda", 32'(bus.oSDA_OE), 32'd0);
    check("s4_async_index", 32'(lut_index), 32'd0);
    check("s4_async_busy", 32'(busy), 32'd0);
    check("s4_exp_empty_at_rst", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    push_entry(8'h1E, 8'h00);
    push_entry(8'h0C, 8'h00);
    rst_n = 1'b1;
    wait_end(4000, cyc);
    check("s4_done", 32'(done), 32'd1);
    check("s4_index", 32'(lut_index), 32'd2);
    check("s4_frames", 32'(frames), 32'd2);
    check("s4_exp_empty", 32'(exp_q.size()), 32'd0);

    // iSTART dropped mid-entry 0
    do_reset();
    mode = 0;
    push_entry(8'h1E, 8'h00);
    push_entry(8'h0C, 8'h00);
    start = 1'b1;
    cyc = 0;
    while (!(frames == 0 && byte_n == 1) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("s5_reached_entry0", 32'(busy), 32'd1);
    start = 1'b0;
    wait_end(4000, cyc);
    check("s5_done", 32'(done), 32'd1);
    check("s5_err", 32'(err), 32'd0);
    check("s5_index", 32'(lut_index), 32'd2);
    check("s5_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
